// File: rtl/rf_writeback.sv
// ============================================================================
//  Module   : rf_writeback
//  Purpose  : Register-bank write front end. It arbitrates ALU results and
//             buffered, extended load returns onto one write port, and keeps a
//             scoreboard of registers that still have a load outstanding.
//  Option   : RF_WB_BYPASS_EN - when the buffer is empty and the ALU is idle,
//             a load goes straight to the write port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_writeback #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_load_valid,
  output logic            o_load_ready,
  input  logic [4:0]      i_load_rd,
  input  logic [XLEN-1:0] i_load_data,
  input  logic [2:0]      i_load_funct3,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_rd,
  output logic [XLEN-1:0] o_rf_data,
  output logic [31:0]     o_busy
);

  localparam int             c_PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW:0]  c_FULL = (c_PW+1)'(DEPTH);

  logic [XLEN-1:0] r_buf_data [DEPTH];
  logic [4:0]      r_buf_rd   [DEPTH];
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_PW:0]   r_count;

  logic            r_rf_we;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_data;
  logic [31:0]     r_busy;

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_bypass;
  logic            w_enq;
  logic [XLEN-1:0] w_ext;
  logic [4:0]      w_commit_rd;
  logic            w_commit_load;
  logic [31:0]     w_clr;
  logic [31:0]     w_set;

  assign w_empty      = (r_count == '0);
  assign o_load_ready = (r_count != c_FULL);
  assign w_push       = i_load_valid & o_load_ready;
  assign w_pop        = ~i_alu_valid & ~w_empty;

`ifdef RF_WB_BYPASS_EN
  assign w_bypass = w_push & w_empty & ~i_alu_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq = w_push & ~w_bypass;

  // Extension is applied once at push so the buffer holds final write data.
  always_comb begin
    w_ext = i_load_data;
    case (i_load_funct3)
      3'b000:  w_ext = {{(XLEN-8){i_load_data[7]}},   i_load_data[7:0]};
      3'b001:  w_ext = {{(XLEN-16){i_load_data[15]}}, i_load_data[15:0]};
      3'b100:  w_ext = {{(XLEN-8){1'b0}},             i_load_data[7:0]};
      3'b101:  w_ext = {{(XLEN-16){1'b0}},            i_load_data[15:0]};
      default: w_ext = i_load_data;
    endcase
  end

  assign w_commit_load = w_pop | w_bypass;
  assign w_commit_rd   = w_pop ? r_buf_rd[r_rptr] : i_load_rd;
  assign w_clr = (w_commit_load && (w_commit_rd != 5'd0)) ? (32'd1 << w_commit_rd) : 32'd0;
  assign w_set = (i_issue_valid && (i_issue_rd != 5'd0)) ? (32'd1 << i_issue_rd) : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_rd[i]   <= '0;
      end
    end else begin
      if (w_enq) begin
        r_buf_data[r_wptr] <= w_ext;
        r_buf_rd[r_wptr]   <= i_load_rd;
        r_wptr             <= r_wptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PW'(1);
      end
      r_count <= r_count + (c_PW+1)'(w_enq) - (c_PW+1)'(w_pop);
    end
  end

  // ALU has priority; an idle cycle keeps rd/data and only drops the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we   <= 1'b0;
      r_rf_rd   <= '0;
      r_rf_data <= '0;
    end else if (i_alu_valid) begin
      r_rf_we   <= (i_alu_rd != 5'd0);
      r_rf_rd   <= i_alu_rd;
      r_rf_data <= i_alu_result;
    end else if (w_pop) begin
      r_rf_we   <= (r_buf_rd[r_rptr] != 5'd0);
      r_rf_rd   <= r_buf_rd[r_rptr];
      r_rf_data <= r_buf_data[r_rptr];
    end else if (w_bypass) begin
      r_rf_we   <= (i_load_rd != 5'd0);
      r_rf_rd   <= i_load_rd;
      r_rf_data <= w_ext;
    end else begin
      r_rf_we   <= 1'b0;
    end
  end

  // Set after clear so a same-edge reissue keeps the bit pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end
  end

  assign o_rf_we   = r_rf_we;
  assign o_rf_rd   = r_rf_rd;
  assign o_rf_data = r_rf_data;
  assign o_busy    = r_busy;

endmodule

`default_nettype wire

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side front end of the CPU register bank. Merges single-cycle ALU results and multi-cycle load returns into the bank's single write port (rd, we, datain).
- Buffers load returns that lose arbitration, and sign/zero-extends load data.
- Keeps a per-register pending-load scoreboard so issue logic can stall dependent instructions.

Parameters:
- DEPTH, 2, load-return buffer entries (power of two, >=2)
- XLEN, 32, data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- alu_valid  in  1  ALU result present this cycle; always accepted
- alu_rd  in  5  ALU destination register
- alu_result  in  XLEN  ALU result
- load_valid  in  1  load return present
- load_ready  out  1  buffer can accept a load return
- load_rd  in  5  load destination register
- load_data  in  XLEN  raw word from memory, already lane-aligned to bit 0
- load_funct3  in  3  RISC-V load funct3
- issue_valid  in  1  a load is being issued this cycle
- issue_rd  in  5  destination of the issued load
- rf_we  out  1  register-bank write enable (registered)
- rf_rd  out  5  register-bank write select (registered)
- rf_data  out  XLEN  register-bank write data (registered)
- busy  out  32  scoreboard; bit i = load to xi outstanding; bit 0 constant 0

Behaviour:
- Reset (reset=0, any time, mid-transfer included): rf_we=0, rf_rd=0, rf_data=0, busy=0, buffer emptied, load_ready=1 from the cycle after release.
- Load extension at push: 000 LB sign-ext byte; 001 LH sign-ext half; 010 LW word; 100 LBU zero-ext byte; 101 LHU zero-ext half; any other code is treated as LW. The buffer stores the extended XLEN value plus rd.
- load_ready = !full. This is a registered-state function with no same-cycle pop credit. A push happens on an edge where load_valid & load_ready.
- Arbitration per edge, ALU first:
  - alu_valid=1: output register takes the ALU write (rf_we=(alu_rd!=0), rf_rd=alu_rd, rf_data=alu_result). The buffer does not pop.
  - Otherwise, if the buffer is non-empty: pop the head into the output register. rf_we=(rd!=0).
  - Otherwise: rf_we=0, and rf_rd/rf_data hold their previous values.
- Latency:
  - ALU: valid in cycle n, write visible in cycle n+1.
  - Load, uncontended: accepted in cycle n, written in cycle n+2.
- Ordering: loads commit in acceptance order. ALU writes can overtake buffered loads. Avoiding WAW hazards is the issuer's job.
- Simultaneous push and pop: both happen, count unchanged. Pointers wrap modulo DEPTH.
- Writes to x0: the entry is consumed, but rf_we stays 0.
- Scoreboard:
  - An edge with issue_valid & issue_rd!=0 sets busy[issue_rd].
  - A load-path commit (pop with rd!=0) clears busy[rd].
  - Set and clear of the same bit on the same edge: set wins.
  - An ALU write never touches busy.
  - Issuing to an already-busy rd is illegal; the issuer must stall on busy. The bit simply stays set.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined: when the buffer is empty, alu_valid=0 and a load is pushed, the extended load is written straight into the output register on that edge and not enqueued. Uncontended load latency becomes n+1. load_ready is unchanged (still !full).
- Undefined: every load passes through the buffer, latency n+2.

Test Plan:
- Reset release, then alu_valid with rd=5, result=0x1234 at cycle 3 -> cycle 4: rf_we=1, rf_rd=5, rf_data=0x00001234; cycle 5: rf_we=0.
- issue rd=7; later load rd=7, funct3=000, data=0x000000F0 -> busy[7]=1 until the write; rf_data=0xFFFFFFF0 at n+2 (n+1 with bypass); busy[7]=0 on the next cycle.
- Extension sweep with data=0x8000_8080, funct3 001/100/101/010/111 -> 0xFFFF8080 / 0x00000080 / 0x00008080 / 0x80008080 / 0x80008080.
- alu_valid held for 4 cycles while 3 loads arrive (DEPTH=2) -> load_ready=0 after the 2nd push and the 3rd is stalled. No load writes while the ALU streams. After alu drops, loads commit in order with no loss.
- ALU rd=0 and load rd=0 -> rf_we never asserts; the buffer drains; busy[0] stays 0.
- Assert reset mid-stream with 2 entries buffered and busy=0x00000880 -> all outputs 0 immediately and busy=0; after release no stale writes appear.
